// File: rtl/game_tick_rx_pkg.sv
// game_pkg: shared defaults, BCD score types and the BCD increment helper for game_tick_rx.
package game_pkg;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCROLL_STEP = 4;
  localparam int DEF_SCORE_DIV = 8;
  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [3:0] score_t;
  localparam score_t SCORE_MAX = 16'h9999;
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    logic c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        c = (s[i] == 4'd9);
        r[i] = c ? 4'd0 : s[i] + 4'd1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/game_tick_rx_if.sv
// game_tick_rx_if: tick input, game controls and scroll/score outputs of game_tick_rx.
interface game_tick_rx_if;
  logic tick_in;
  logic run;
  logic clear;
  logic tick;
  logic [9:0] scroll_x;
  logic [15:0] score_bcd;
  logic score_max;
  logic [27:0] tick_period;
  modport master (output tick_in, run, clear, input tick, scroll_x, score_bcd, score_max, tick_period);
  modport slave (input tick_in, run, clear, output tick, scroll_x, score_bcd, score_max, tick_period);
endinterface

// File: rtl/game_tick_rx_bcd_counter4.sv
// bcd_counter4: saturating four-digit BCD incrementer; clr wins over inc.
module bcd_counter4
  import game_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   inc,
  output score_t q,
  output logic   max
);
  assign max = (q == SCORE_MAX);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !max) q <= bcd_inc(q);
  end
endmodule

// File: rtl/game_tick_rx.sv
// game_tick_rx: synchronizes the divided game clock into a tick strobe and advances scroll and BCD score.
// Define GAME_TICK_PERIOD_MEAS_EN to measure clk cycles between ticks on tick_period.
module game_tick_rx
  import game_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCROLL_STEP = DEF_SCROLL_STEP,
  parameter int SCORE_DIV = DEF_SCORE_DIV
) (
  input logic clk,
  input logic rst_n,
  game_tick_rx_if.slave bus
);
  logic s1, s2, s3, tick_q;
  logic [9:0] scroll;
  logic [7:0] sub;
  logic [10:0] sum, nxt;
  logic adv, sub_wrap;
  score_t score;
  logic score_max;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {s3, s2, s1, tick_q} <= '0;
    else {s3, s2, s1, tick_q} <= {s2, s1, bus.tick_in, s2 & ~s3};
  end
  always_comb begin
    adv = tick_q & bus.run;
    sum = {1'b0, scroll} + 11'(SCROLL_STEP);
    nxt = (sum >= 11'(SCREEN_W)) ? sum - 11'(SCREEN_W) : sum;
    sub_wrap = (sub == 8'(SCORE_DIV - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll <= '0;
      sub <= '0;
    end else if (bus.clear) begin
      scroll <= '0;
      sub <= '0;
    end else if (adv) begin
      scroll <= nxt[9:0];
      sub <= sub_wrap ? 8'd0 : sub + 8'd1;
    end
  end
  bcd_counter4 u_score (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.clear),
    .inc(adv & sub_wrap),
    .q(score),
    .max(score_max)
  );
`ifdef GAME_TICK_PERIOD_MEAS_EN
  logic [27:0] cnt, period;
  // counter saturates so a stalled game reads as "very slow" rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      period <= '0;
    end else if (tick_q) begin
      cnt <= 28'd1;
      period <= cnt;
    end else if (!(&cnt)) begin
      cnt <= cnt + 28'd1;
    end
  end
  assign bus.tick_period = period;
`else
  assign bus.tick_period = '0;
`endif
  assign bus.tick = tick_q;
  assign bus.scroll_x = scroll;
  assign bus.score_bcd = score;
  assign bus.score_max = score_max;
endmodule

// File: tb/tb_game_tick_rx.sv
// tb_game_tick_rx: directed checks of tick latency, scroll wrap, BCD score, run/clear, period and glitches.
module tb_game_tick_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int na = 0;
  int nb = 0;
  int n0;
  game_tick_rx_if a ();
  game_tick_rx_if b ();
  game_tick_rx dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  game_tick_rx #(.SCREEN_W(640), .SCROLL_STEP(7), .SCORE_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (a.tick) na++;
    if (b.tick) nb++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input bit sel, input int hi, input int lo);
    @(negedge clk);
    if (sel) b.tick_in = 1'b1; else a.tick_in = 1'b1;
    repeat (hi) @(negedge clk);
    if (sel) b.tick_in = 1'b0; else a.tick_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask
  initial begin
    {a.tick_in, a.run, a.clear, b.tick_in, b.run, b.clear} = 6'b010_010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a.tick_in = ~a.tick_in;
      b.tick_in = ~b.tick_in;
    end
    a.tick_in = 1'b0;
    b.tick_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_tick", 32'(a.tick), 0);
    check("rst_scroll", 32'(a.scroll_x), 0);
    check("rst_score", 32'(a.score_bcd), 0);
    check("rst_max", 32'(a.score_max), 0);
    check("rst_period", 32'(a.tick_period), 0);
    check("rst_tick_count", 32'(na), 0);
    a.tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("lat_e1_tick", 32'(a.tick), 0);
    @(posedge clk);
    #1 check("lat_e2_tick", 32'(a.tick), 1);
    check("lat_e2_scroll", 32'(a.scroll_x), 0);
    @(posedge clk);
    #1 check("lat_e3_tick", 32'(a.tick), 0);
    check("lat_e3_scroll", 32'(a.scroll_x), 4);
    @(negedge clk);
    a.tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check("lat_count", 32'(na), 1);
    for (int i = 0; i < 7; i++) pulse(0, 3, 2);
    check("s8_score", 32'(a.score_bcd), 32'h0001);
    check("s8_scroll", 32'(a.scroll_x), 32);
    for (int i = 0; i < 151; i++) pulse(0, 3, 2);
    check("s159_scroll", 32'(a.scroll_x), 636);
    check("s159_score", 32'(a.score_bcd), 32'h0019);
    pulse(0, 3, 2);
    check("s160_scroll", 32'(a.scroll_x), 0);
    check("s160_score", 32'(a.score_bcd), 32'h0020);
    a.run = 1'b0;
    n0 = na;
    for (int i = 0; i < 5; i++) pulse(0, 3, 2);
    check("norun_strobes", 32'(na - n0), 5);
    check("norun_scroll", 32'(a.scroll_x), 0);
    check("norun_score", 32'(a.score_bcd), 32'h0020);
    a.run = 1'b1;
    pulse(0, 3, 2);
    check("pre_clr_scroll", 32'(a.scroll_x), 4);
    @(negedge clk);
    a.tick_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("clr_tick_high", 32'(a.tick), 1);
    @(negedge clk);
    a.clear = 1'b1;
    @(negedge clk);
    a.clear = 1'b0;
    check("clr_scroll", 32'(a.scroll_x), 0);
    check("clr_score", 32'(a.score_bcd), 0);
    a.tick_in = 1'b0;
    repeat (3) @(negedge clk);
    pulse(0, 3, 2);
    check("post_clr_scroll", 32'(a.scroll_x), 4);
    check("post_clr_score", 32'(a.score_bcd), 0);
    for (int i = 0; i < 7; i++) pulse(0, 3, 2);
    check("post_clr_score8", 32'(a.score_bcd), 32'h0001);
    check("post_clr_scroll8", 32'(a.scroll_x), 32);
    a.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 1000, 999);
`ifdef GAME_TICK_PERIOD_MEAS_EN
      if (i > 0) check("period_2000", 32'(a.tick_period), 2000);
`else
      check("period_off", 32'(a.tick_period), 0);
`endif
    end
    for (int i = 0; i < 2; i++) pulse(0, 750, 749);
`ifdef GAME_TICK_PERIOD_MEAS_EN
    check("period_1500", 32'(a.tick_period), 1500);
`else
    check("period_off_2", 32'(a.tick_period), 0);
`endif
    n0 = na;
    pulse(0, 1, 4);
    check("glitch1_le1", 32'(na - n0 <= 1), 1);
    n0 = na;
    pulse(0, 3, 4);
    check("glitch3_eq1", 32'(na - n0), 1);
    for (int i = 0; i < 99; i++) pulse(1, 3, 2);
    check("b99_score", 32'(b.score_bcd), 32'h0099);
    check("b99_scroll", 32'(b.scroll_x), 53);
    pulse(1, 3, 2);
    check("b100_score", 32'(b.score_bcd), 32'h0100);
    check("b100_scroll", 32'(b.scroll_x), 60);
    for (int i = 0; i < 448; i++) pulse(1, 3, 2);
    check("b548_scroll", 32'(b.scroll_x), 636);
    check("b548_score", 32'(b.score_bcd), 32'h0548);
    pulse(1, 3, 2);
    check("b549_scroll", 32'(b.scroll_x), 3);
    for (int i = 0; i < 9449; i++) pulse(1, 3, 2);
    check("b9998_score", 32'(b.score_bcd), 32'h9998);
    check("b9998_max", 32'(b.score_max), 0);
    pulse(1, 3, 2);
    check("b9999_score", 32'(b.score_bcd), 32'h9999);
    check("b9999_max", 32'(b.score_max), 1);
    check("b9999_scroll", 32'(b.scroll_x), 233);
    for (int i = 0; i < 8; i++) pulse(1, 3, 2);
    check("bsat_score", 32'(b.score_bcd), 32'h9999);
    check("bsat_max", 32'(b.score_max), 1);
    check("b_tick_count", 32'(nb), 10007);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_tick_rx.md
# game_tick_rx

Receiving end of the game-speed tick. Takes the free-running, progressively faster divided clock from the game clock divider as a plain data input in the 100 MHz `clk` domain, synchronizes it and edge-detects it into a one-cycle `tick` strobe. On each strobe it advances the horizontal scroll offset and the BCD score. Its outputs feed the obstacle renderer and the seven-segment score display.

## Interface
- `SCREEN_W`, 640: scroll wrap modulus in pixels, at most 1024.
- `SCROLL_STEP`, 4: pixels advanced per tick, less than `SCREEN_W`.
- `SCORE_DIV`, 8: ticks per score increment, at least 1.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick_in` input 1: divided game clock, asynchronous to the logic and treated as data.
- `run` input 1: game running; when low, scroll and score hold.
- `clear` input 1: synchronous restart of scroll, score and the sub-counter.
- `tick` output 1: one-cycle strobe per rising edge of `tick_in`.
- `scroll_x` output 10: scroll offset, 0..`SCREEN_W`-1.
- `score_bcd` output 16: four BCD digits, with [3:0] as the units digit.
- `score_max` output 1: high while `score_bcd` equals 16'h9999.
- `tick_period` output 28: clk cycles between the last two ticks (macro-gated).

## Operation
- Synchronizer: two flops `s1`/`s2`, then a history flop `s3`. Edge = `s2 & ~s3`. The edge is registered into `tick`.
- Only rising edges of `tick_in` count, so there is one tick per full divided-clock period. Falling edges are ignored.
- On a cycle where `tick`=1 and `run`=1:
  - `sum = scroll_x + SCROLL_STEP`, computed 11 bits wide.
  - If `sum >= SCREEN_W`, then `scroll_x <= sum - SCREEN_W`; otherwise `scroll_x <= sum`.
  - The 8-bit sub-counter increments. On reaching `SCORE_DIV`-1 it returns to 0 and the score increments by one in BCD.
- BCD increment: any digit at 9 rolls to 0 with carry into the next digit. At 9999 the score saturates: it holds and `score_max`=1. The sub-counter keeps wrapping.
- `tick` with `run`=0: the strobe is still emitted, scroll, score and sub-counter hold, and the period measure still updates.
- `clear`=1: `scroll_x`, `score_bcd` and the sub-counter go to 0 on the next edge. `clear` has priority over a simultaneous tick. Synchronizer and period state are unaffected.
- Reset: every flop is cleared, so `tick`=0, `scroll_x`=0, `score_bcd`=0, `score_max`=0, `tick_period`=0, and `s1`/`s2`/`s3`=0.
- Reset asserted mid-operation aborts everything immediately. If `tick_in` is already high at reset release, one `tick` is produced after synchronization. This is accepted behaviour.

## Timing
- Latency: `tick_in` is first sampled high at edge E0, giving `s1`@E0, `s2`@E1 and `tick`=1 after E2. The strobe lasts exactly one cycle, then drops after E3.
- `scroll_x`, `score_bcd` and `score_max` change on the edge that ends the `tick` cycle, one cycle after `tick` rises.
- The minimum `tick_in` high or low time is 3 clk cycles. Shorter pulses may be lost.
- The divider's minimum half-period of ~97k cycles gives a huge margin.
- `score_max` is combinational from `score_bcd`.

## Configuration
- `GAME_TICK_PERIOD_MEAS_EN` defined:
  - A 28-bit cycle counter increments every cycle and saturates at all-ones.
  - On each `tick`, its value is copied to `tick_period` and the counter is reloaded with 1.
- Macro undefined: the counter logic is absent and `tick_period` is tied to 0.

## Structure
- Package `game_pkg` holds:
  - Default `SCREEN_W`, `SCROLL_STEP` and `SCORE_DIV` localparams.
  - `bcd_digit_t` (4-bit) and `score_t` (4×`bcd_digit_t`) typedefs.
  - `SCORE_MAX` = 16'h9999.
- Sub-module `bcd_counter4` is a saturating 4-digit BCD incrementer with `inc`, `clr` and `max` signals. The score is instantiated from it.

## Test plan
- Reset: hold `rst_n`=0 with `tick_in` toggling, then release with `tick_in`=0. Required: all outputs 0; first `tick_in` rise gives `tick` high for exactly 1 cycle, 3 edges later.
- Scroll wrap, `SCREEN_W`=640, `SCROLL_STEP`=4, `run`=1: after 159 ticks `scroll_x`=636; the 160th tick gives 0. With `SCROLL_STEP`=7, 636+7 gives 3.
- Score: 8 ticks → `score_bcd`=16'h0001. Preload 16'h0099 and 8 ticks → 16'h0100. Preload 9999 and 8 ticks → 9999 held, `score_max`=1.
- `run`=0 over 5 ticks: 5 `tick` strobes seen, `scroll_x`/`score_bcd` unchanged. `clear` asserted on a tick cycle → `scroll_x`=0, `score_bcd`=0, no advance.
- With `GAME_TICK_PERIOD_MEAS_EN`, `tick_in` period 2000 cycles → `tick_period`=2000 from the second tick onward. Change the period to 1500 → next update reads 1500.
- Glitch: a 1-cycle `tick_in` pulse may or may not give a tick, but never more than 1. A 3-cycle pulse always gives exactly 1.
